alu_issue_sequencer: RTL and testbench

Parametrised, sequential successor to the combinational ALU decoder in the Filter-GPU control unit. Accepts one {ALUOp, Funct} instruction per handshake and decodes it to ALUControl/FlagW/NoWrite/SrcA. Emits one or more registered control beats: lane-serial across LANES vector lanes, and MUL_CYCLES beats per lane for multi-cycle MUL. Sits between the main decoder and the ALU datapath, with valid/ready on both sides.

---
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Handshake bundle between the main decoder, the ALU issue sequencer and the ALU datapath.
// master = instruction source / beat consumer side, slave = the sequencer.
interface alu_issue_if #(
  parameter int LANES  = 4,
  parameter int STEP_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              alu_op;
  logic [5:0]        funct;
  logic              vec_mode;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        alu_control;
  logic [1:0]        flag_w;
  logic              no_write;
  logic              src_a;
  logic [LANES-1:0]  lane_en;
  logic [STEP_W-1:0] step;
  logic              out_last;
  logic              illegal;

  modport master (
    output in_valid, alu_op, funct, vec_mode, out_ready,
    input  in_ready, out_valid, alu_control, flag_w, no_write, src_a,
           lane_en, step, out_last, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, vec_mode, out_ready,
    output in_ready, out_valid, alu_control, flag_w, no_write, src_a,
           lane_en, step, out_last, illegal
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Decodes one {ALUOp, Funct} instruction per handshake and issues registered control beats,
// lane-serial across the vector lanes and MUL_CYCLES beats per lane for multi-cycle MUL.
module alu_issue_sequencer #(
  parameter int LANES      = 4,
  parameter int MUL_CYCLES = 3,
  parameter int STEP_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_issue_if.slave  bus
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_CYCLES - 1);

  typedef struct packed {
    logic [3:0] ctrl;
    logic [1:0] flagw;
    logic       nw;
    logic       srca;
    logic       mul;
    logic       ill;
  } dec_t;

  typedef enum logic {IDLE, BEAT} state_t;

  function automatic dec_t mk(input logic [3:0] ctrl, input logic [1:0] flagw,
                              input logic nw, input logic srca, input logic mul);
    dec_t d;
    d.ctrl  = ctrl;
    d.flagw = flagw;
    d.nw    = nw;
    d.srca  = srca;
    d.mul   = mul;
    d.ill   = 1'b0;
    return d;
  endfunction

  function automatic dec_t decode(input logic alu_op, input logic [5:0] funct);
    dec_t d;
    // Unrecognised encodings fall through to the illegal beat shape.
    d.ctrl  = 4'b0000;
    d.flagw = 2'b00;
    d.nw    = 1'b1;
    d.srca  = 1'b0;
    d.mul   = 1'b0;
    d.ill   = 1'b1;
    if (!alu_op) begin
      d = mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
    end else begin
      casez (funct)
        6'b?01000: d = mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0);
        6'b?01001: d = mk(4'b0000, 2'b11, 1'b0, 1'b0, 1'b0);
        6'b?00100: d = mk(4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
        6'b?00101: d = mk(4'b0001, 2'b11, 1'b0, 1'b0, 1'b0);
        6'b?00000: d = mk(4'b0010, 2'b00, 1'b0, 1'b0, 1'b0);
        6'b?00001: d = mk(4'b0010, 2'b10, 1'b0, 1'b0, 1'b0);
        6'b?11000: d = mk(4'b0011, 2'b00, 1'b0, 1'b0, 1'b0);
        6'b?11001: d = mk(4'b0011, 2'b10, 1'b0, 1'b0, 1'b0);
        6'b?10101: d = mk(4'b0001, 2'b11, 1'b1, 1'b0, 1'b0);
        6'b?00010: d = mk(4'b0101, 2'b00, 1'b0, 1'b0, 1'b1);
        6'b011010: d = mk(4'b1001, 2'b00, 1'b0, 1'b0, 1'b0);
        6'b111010: d = mk(4'b0000, 2'b00, 1'b0, 1'b1, 1'b0);
        6'b111110: d = mk(4'b0001, 2'b00, 1'b0, 1'b1, 1'b0);
        6'b010010: d = mk(4'b0111, 2'b00, 1'b0, 1'b0, 1'b0);
        default:   d = d;
      endcase
    end
    return d;
  endfunction

  function automatic logic is_last(input dec_t d, input logic vec,
                                   input logic [LANE_W-1:0] lane,
                                   input logic [STEP_W-1:0] step);
    logic [LANE_W-1:0] lane_end;
    logic [STEP_W-1:0] step_end;
    lane_end = vec ? LANE_LAST : '0;
    step_end = d.mul ? STEP_LAST : '0;
    return d.ill | ((lane == lane_end) && (step == step_end));
  endfunction

  state_t            state_q, state_d;
  dec_t              dec_q, dec_d;
  logic              vec_q, vec_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              out_valid_q, out_valid_d;
  logic              last_q, last_d;
  logic [LANES-1:0]  lane_en_q, lane_en_d;
  logic [1:0]        flag_w_q, flag_w_d;
  logic              in_ready;
  logic              accept;
  logic              advance;

  // Gated by rst_n so nothing is accepted in a reset cycle.
  assign in_ready = rst_n & ((state_q == IDLE) | (out_valid_q & bus.out_ready & last_q));
  assign accept   = in_ready & bus.in_valid;
  assign advance  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    vec_d   = vec_q;
    lane_d  = lane_q;
    step_d  = step_q;
    if (accept) begin
      state_d = BEAT;
      dec_d   = decode(bus.alu_op, bus.funct);
      vec_d   = bus.vec_mode;
      lane_d  = '0;
      step_d  = '0;
    end else if (advance) begin
      if (last_q) begin
        state_d = IDLE;
      end else if (dec_q.mul && (step_q != STEP_LAST)) begin
        step_d = step_q + STEP_W'(1);
      end else begin
        step_d = '0;
        lane_d = lane_q + LANE_W'(1);
      end
    end
    last_d      = is_last(dec_d, vec_d, lane_d, step_d);
    lane_en_d   = dec_d.ill ? '0 : (LANES'(1) << lane_d);
    flag_w_d    = last_d ? dec_d.flagw : 2'b00;
    out_valid_d = (state_d == BEAT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dec_q       <= '0;
      vec_q       <= 1'b0;
      lane_q      <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      lane_en_q   <= '0;
      flag_w_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      vec_q       <= vec_d;
      lane_q      <= lane_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      lane_en_q   <= lane_en_d;
      flag_w_q    <= flag_w_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.alu_control = dec_q.ctrl;
  assign bus.flag_w      = flag_w_q;
  assign bus.no_write    = dec_q.nw;
  assign bus.src_a       = dec_q.srca;
  assign bus.lane_en     = lane_en_q;
  assign bus.step        = step_q;
  assign bus.out_last    = last_q;
  assign bus.illegal     = dec_q.ill;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Randomised and directed bench for alu_issue_sequencer against a beat-list reference model.
module tb_alu_issue_sequencer;
  localparam int LN = 4;
  localparam int MC = 3;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  alu_issue_if #(.LANES(LN), .STEP_W(SW)) bus ();

  alu_issue_sequencer #(.LANES(LN), .MUL_CYCLES(MC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observed beat: {valid, ctrl, flag_w, no_write, src_a, lane_en, step, last, illegal}
  function automatic logic [16:0] obs();
    return {bus.out_valid, bus.alu_control, bus.flag_w, bus.no_write, bus.src_a,
            bus.lane_en, bus.step, bus.out_last, bus.illegal};
  endfunction

  // Reference decode straight from the instruction table.
  function automatic void ref_dec(input logic op, input logic [5:0] f,
                                  output logic [3:0] ctrl, output logic [1:0] fw,
                                  output logic nw, output logic sa,
                                  output bit mul, output bit ill);
    ctrl = 4'b0000; fw = 2'b00; nw = 1'b0; sa = 1'b0; mul = 0; ill = 0;
    if (!op) return;
    if      (f[4:0] == 5'b01000) ctrl = 4'b0000;
    else if (f[4:0] == 5'b01001) begin ctrl = 4'b0000; fw = 2'b11; end
    else if (f[4:0] == 5'b00100) ctrl = 4'b0001;
    else if (f[4:0] == 5'b00101) begin ctrl = 4'b0001; fw = 2'b11; end
    else if (f[4:0] == 5'b00000) ctrl = 4'b0010;
    else if (f[4:0] == 5'b00001) begin ctrl = 4'b0010; fw = 2'b10; end
    else if (f[4:0] == 5'b11000) ctrl = 4'b0011;
    else if (f[4:0] == 5'b11001) begin ctrl = 4'b0011; fw = 2'b10; end
    else if (f[4:0] == 5'b10101) begin ctrl = 4'b0001; fw = 2'b11; nw = 1'b1; end
    else if (f[4:0] == 5'b00010) begin ctrl = 4'b0101; mul = 1; end
    else if (f == 6'b011010) ctrl = 4'b1001;
    else if (f == 6'b111010) begin ctrl = 4'b0000; sa = 1'b1; end
    else if (f == 6'b111110) begin ctrl = 4'b0001; sa = 1'b1; end
    else if (f == 6'b010010) ctrl = 4'b0111;
    else begin nw = 1'b1; ill = 1; end
  endfunction

  // Issue one instruction and check every beat; mode 0 = always ready,
  // 1 = out_ready toggling 1,0,1..., 2 = random backpressure.
  task automatic play_instr(input string name, input logic op, input logic [5:0] f,
                            input logic vec, input int mode);
    logic [3:0] ctrl; logic [1:0] fw; logic nw, sa; bit mul, ill;
    int per, nl, n, t, cyc;
    ref_dec(op, f, ctrl, fw, nw, sa, mul, ill);
    per = mul ? MC : 1;
    nl  = vec ? LN : 1;
    n   = ill ? 1 : nl * per;
    cyc = 0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.funct = f; bus.vec_mode = vec;
    bus.out_ready = 1'b0;
    #1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    n_total++;
    if (t >= 20) begin
      $display("FAIL %s accept: in_ready never rose (got %b, required 1)", name, bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [16:0] exp;
      bit done, r;
      int guard;
      bit lst;
      lst = (i == n - 1);
      if (ill) exp = {1'b1, 4'b0000, 2'b00, 1'b1, 1'b0, 4'b0000, 2'b00, 1'b1, 1'b1};
      else     exp = {1'b1, ctrl, lst ? fw : 2'b00, nw, sa, 4'(1 << (i / per)),
                      2'(i % per), lst, 1'b0};
      done = 0; guard = 0;
      while (!done) begin
        n_total++;
        if (obs() !== exp)
          $display("FAIL %s beat %0d: got %h, required %h", name, i, obs(), exp);
        else n_pass++;
        case (mode)
          0:       r = 1;
          1:       r = (cyc % 2 == 0);
          default: r = ($urandom_range(99) < 60);
        endcase
        if (guard >= 30) r = 1;
        bus.out_ready = r;
        bus.in_valid  = !lst;
        #1;
        n_total++;
        if (bus.in_ready !== (r & lst))
          $display("FAIL %s in_ready beat %0d: got %b, required %b", name, i, bus.in_ready, r & lst);
        else n_pass++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc++; guard++;
        done = r;
      end
    end
    bus.out_ready = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL %s drain: out_valid got %b, required 0", name, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.alu_op = 1'b0; bus.funct = 6'd0;
    bus.vec_mode = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (obs() !== 17'd0) $display("FAIL reset outputs: got %h, required 0", obs());
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset in_ready: got %b, required 0", bus.in_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL post-reset: in_ready/out_valid got %b%b, required 10", bus.in_ready, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_adds();
    play_instr("adds", 1'b1, 6'b001001, 1'b0, 0);
  endtask

  task automatic test_cmp_vec();
    play_instr("cmp_vec", 1'b1, 6'b010101, 1'b1, 0);
  endtask

  task automatic test_mul_stall();
    play_instr("mul_stall", 1'b1, 6'b000010, 1'b1, 1);
    play_instr("mul_scalar", 1'b1, 6'b100010, 1'b0, 2);
  endtask

  task automatic test_illegal();
    play_instr("illegal", 1'b1, 6'b101111, 1'b1, 0);
    play_instr("illegal_b", 1'b1, 6'b110010, 1'b0, 1);
  endtask

  task automatic test_non_alu();
    play_instr("alu_op0", 1'b0, 6'b101111, 1'b1, 2);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = 1'b1; bus.funct = 6'b011000; bus.vec_mode = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.funct = 6'b111010; bus.out_ready = 1'b1;
    #1;
    n_total++;
    if (obs() !== {1'b1, 4'b0011, 2'b00, 1'b0, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0})
      $display("FAIL b2b orr beat: got %h, required %h", obs(),
               {1'b1, 4'b0011, 2'b00, 1'b0, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0});
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL b2b in_ready: got %b, required 1", bus.in_ready);
    else n_pass++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++;
    if (obs() !== {1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b0})
      $display("FAIL b2b mov beat: got %h, required %h", obs(),
               {1'b1, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b0});
    else n_pass++;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b drain: out_valid got %b, required 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = 1'b1; bus.funct = 6'b000100; bus.vec_mode = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs() !== {1'b1, 4'b0001, 2'b00, 1'b0, 1'b0, 4'b0010, 2'b00, 1'b0, 1'b0})
      $display("FAIL rstmid beat2: got %h, required %h", obs(),
               {1'b1, 4'b0001, 2'b00, 1'b0, 1'b0, 4'b0010, 2'b00, 1'b0, 1'b0});
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs() !== 17'd0) $display("FAIL rstmid outputs: got %h, required 0", obs());
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b0) $display("FAIL rstmid in_ready low: got %b, required 0", bus.in_ready);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL rstmid release: in_ready/out_valid got %b%b, required 10", bus.in_ready, bus.out_valid);
    else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] legal [14] = '{6'b001000, 6'b001001, 6'b000100, 6'b000101, 6'b000000,
                               6'b000001, 6'b011000, 6'b011001, 6'b010101, 6'b000010,
                               6'b011010, 6'b111010, 6'b111110, 6'b010010};
    for (int k = 0; k < 40; k++) begin
      logic [5:0] f;
      logic op, vec;
      if ($urandom_range(3) != 0) begin
        f = legal[$urandom_range(13)];
        if (f != 6'b011010 && f != 6'b111010 && f != 6'b111110 && f != 6'b010010)
          f[5] = 1'($urandom_range(1));
      end else begin
        f = 6'($urandom_range(63));
      end
      op  = ($urandom_range(7) != 0);
      vec = 1'($urandom_range(1));
      play_instr("random", op, f, vec, int'($urandom_range(2)));
    end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_cmp_vec();
    test_mul_stall();
    test_illegal();
    test_non_alu();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
